// File: rtl/mpt_pkg.sv
// Shared MPT walker types: walk transaction, permission bits, access/cause enums
// and the response returned toward the requester.
package mpt_pkg;

  localparam int unsigned MPT_ADDR_W = 19;
  localparam int unsigned MPT_ID_W   = 4;

  typedef enum logic [1:0] {
    MPT_WALKING_ROOT = 2'd0,
    MPT_WALKING_MID  = 2'd1,
    MPT_WALKING_LEAF = 2'd2,
    MPT_WALKING_SKIP = 2'd3
  } mpt_walking_e;

  typedef enum logic [1:0] {
    MPT_ACCESS_READ  = 2'd0,
    MPT_ACCESS_WRITE = 2'd1,
    MPT_ACCESS_EXEC  = 2'd2
  } mpt_access_e;

  typedef enum logic [1:0] {
    MPT_CAUSE_NONE        = 2'd0,
    MPT_CAUSE_WALK_FAULT  = 2'd1,
    MPT_CAUSE_PERM_DENIED = 2'd2,
    MPT_CAUSE_PERM_FORMAT = 2'd3
  } mpt_check_cause_e;

  typedef struct packed {
    logic x;
    logic w;
    logic r;
  } mpt_perm_t;

  // 32 bits total, matching the walking-stage pipeline width
  typedef struct packed {
    logic                  valid;
    logic                  fault;
    mpt_walking_e          walking;
    mpt_perm_t             perm;
    mpt_access_e           access;
    logic [MPT_ID_W-1:0]   id;
    logic [MPT_ADDR_W-1:0] addr;
  } mptw_transaction_t;

  typedef struct packed {
    logic                  valid;
    logic                  allow;
    mpt_check_cause_e      cause;
    logic [4:0]            rsvd;
    logic [MPT_ID_W-1:0]   id;
    logic [MPT_ADDR_W-1:0] addr;
  } mpt_response_t;

endpackage

// File: rtl/mpt_perm_decoder.sv
// Combinational leaf-permission check: turns a completed walk into allow/cause.
// Shared with the PLB hit path.
module mpt_perm_decoder
  import mpt_pkg::*;
(
  input  mptw_transaction_t txn,
  output logic              allow,
  output mpt_check_cause_e  cause
);

  logic access_ok;
  logic unused_fields;

  always_comb begin
    access_ok = 1'b0;
    case (txn.access)
      MPT_ACCESS_READ:  access_ok = txn.perm.r;
      MPT_ACCESS_WRITE: access_ok = txn.perm.r && txn.perm.w;
      MPT_ACCESS_EXEC:  access_ok = txn.perm.x;
      default:          access_ok = 1'b0;
    endcase
  end

  // Priority: walk fault, skip (bare/outside MPT), reserved W-without-R, access bits
  always_comb begin
    allow = 1'b0;
    cause = MPT_CAUSE_NONE;
    if (txn.fault) begin
      cause = MPT_CAUSE_WALK_FAULT;
    end else if (txn.walking == MPT_WALKING_SKIP) begin
      allow = 1'b1;
    end else if (txn.perm.w && !txn.perm.r) begin
      cause = MPT_CAUSE_PERM_FORMAT;
    end else if (!access_ok) begin
      cause = MPT_CAUSE_PERM_DENIED;
    end else begin
      allow = 1'b1;
    end
  end

  assign unused_fields = ^{txn.valid, txn.id, txn.addr};

endmodule

// File: rtl/mpt_check_stage.sv
// Final MPT walker stage: 2-entry skid buffer, permission check, registered response.
// Optional sticky deny log and counter built when MPT_CHECK_FAULT_LOG_EN is defined.
module mpt_check_stage
  import mpt_pkg::*;
#(
  parameter int unsigned PIPELINE_SLAVE_DATA_WIDTH = 32,
  parameter int unsigned RESPONSE_DATA_WIDTH       = 32,
  parameter int unsigned FAULT_COUNT_WIDTH         = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 stage_slave_valid,
  output logic                                 stage_slave_ready,
  input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0] stage_slave_data,
  output logic                                 stage_master_valid,
  input  logic                                 stage_master_ready,
  output logic [RESPONSE_DATA_WIDTH-1:0]       stage_master_data,
  output logic                                 fault_valid_o,
  output logic [63:0]                          fault_addr_o,
  output mpt_check_cause_e                     fault_cause_o,
  output logic [FAULT_COUNT_WIDTH-1:0]         fault_count_o,
  input  logic                                 fault_clear_i
);

  mptw_transaction_t in_txn, head;
  mptw_transaction_t main_p0, skid_p0, main_d, skid_d;
  logic              main_vld_p0, skid_vld_p0, main_vld_d, skid_vld_d;
  logic              ready_p0;
  logic              in_fire, head_vld, head_take, load_out, out_free;
  logic              dec_allow;
  mpt_check_cause_e  dec_cause;
  mpt_response_t     resp_d, resp_p1;
  logic              vld_p1;

  assign in_txn    = mptw_transaction_t'(stage_slave_data);
  assign in_fire   = stage_slave_valid && ready_p0;
  assign out_free  = !vld_p1 || stage_master_ready;
  // An empty buffer lets the arriving transaction be decided in its own cycle
  assign head_vld  = main_vld_p0 || in_fire;
  assign head      = main_vld_p0 ? main_p0 : in_txn;
  // Bubbles are dropped regardless of output backpressure
  assign head_take = head_vld && (!head.valid || out_free);
  assign load_out  = head_take && head.valid;

  mpt_perm_decoder u_perm_decoder (
    .txn   (head),
    .allow (dec_allow),
    .cause (dec_cause)
  );

  always_comb begin
    main_vld_d = main_vld_p0;
    skid_vld_d = skid_vld_p0;
    main_d     = main_p0;
    skid_d     = skid_p0;
    if (head_take) begin
      if (main_vld_p0) begin
        if (skid_vld_p0) begin
          main_d     = skid_p0;
          main_vld_d = 1'b1;
          skid_vld_d = in_fire;
          skid_d     = in_txn;
        end else begin
          main_d     = in_txn;
          main_vld_d = in_fire;
          skid_vld_d = 1'b0;
        end
      end
    end else if (in_fire) begin
      if (!main_vld_p0) begin
        main_d     = in_txn;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = in_txn;
        skid_vld_d = 1'b1;
      end
    end
  end

  // Stage p0: input skid buffer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_vld_p0 <= 1'b0;
      skid_vld_p0 <= 1'b0;
      ready_p0    <= 1'b1;
    end else begin
      main_vld_p0 <= main_vld_d;
      skid_vld_p0 <= skid_vld_d;
      ready_p0    <= !skid_vld_d;
    end
  end

  always_ff @(posedge clk_i) begin
    main_p0 <= main_d;
    skid_p0 <= skid_d;
  end

  always_comb begin
    resp_d       = '0;
    resp_d.valid = 1'b1;
    resp_d.allow = dec_allow;
    resp_d.cause = dec_cause;
    resp_d.id    = head.id;
    resp_d.addr  = head.addr;
  end

  // Stage p1: registered response slot, held stable under backpressure
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1  <= 1'b0;
      resp_p1 <= '0;
    end else if (out_free) begin
      vld_p1 <= load_out;
      if (load_out) resp_p1 <= resp_d;
    end
  end

  assign stage_slave_ready  = ready_p0;
  assign stage_master_valid = vld_p1;
  assign stage_master_data  = resp_p1;

`ifdef MPT_CHECK_FAULT_LOG_EN
  logic                         deny_load;
  logic                         fault_valid_q;
  logic [63:0]                  fault_addr_q;
  mpt_check_cause_e             fault_cause_q;
  logic [FAULT_COUNT_WIDTH-1:0] fault_count_q;

  assign deny_load = load_out && !dec_allow;

  // A deny loading in the same cycle as a clear takes precedence over the clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_cause_q <= MPT_CAUSE_NONE;
      fault_count_q <= '0;
    end else begin
      if (deny_load) begin
        if (fault_clear_i) begin
          fault_count_q <= FAULT_COUNT_WIDTH'(1);
        end else if (fault_count_q != '1) begin
          fault_count_q <= fault_count_q + FAULT_COUNT_WIDTH'(1);
        end
      end else if (fault_clear_i) begin
        fault_count_q <= '0;
      end
      if (deny_load && (!fault_valid_q || fault_clear_i)) begin
        fault_valid_q <= 1'b1;
        fault_addr_q  <= 64'(head.addr);
        fault_cause_q <= dec_cause;
      end else if (fault_clear_i) begin
        fault_valid_q <= 1'b0;
        fault_addr_q  <= '0;
        fault_cause_q <= MPT_CAUSE_NONE;
      end
    end
  end

  assign fault_valid_o = fault_valid_q;
  assign fault_addr_o  = fault_addr_q;
  assign fault_cause_o = fault_cause_q;
  assign fault_count_o = fault_count_q;
`else
  logic unused_fault_clear;

  assign unused_fault_clear = fault_clear_i;
  assign fault_valid_o      = 1'b0;
  assign fault_addr_o       = '0;
  assign fault_cause_o      = MPT_CAUSE_NONE;
  assign fault_count_o      = '0;
`endif

endmodule

// File: doc/mpt_check_stage.md
# mpt_check_stage

Final stage of the MPT walker pipeline, directly downstream of the last `walking_stage` level. It consumes completed walk transactions, takes the leaf MPTE permission bits, and checks them against the requested access type. It emits one allow/deny response per valid transaction toward the requester. It also maintains an optional sticky fault log for debug and CSR readout.

## Interface

Parameters:
- `PIPELINE_SLAVE_DATA_WIDTH`, 32: width of the incoming `mptw_transaction_t`.
- `RESPONSE_DATA_WIDTH`, 32: width of the outgoing `mpt_response_t`.
- `FAULT_COUNT_WIDTH`, 16: width of the saturating deny counter.

Ports:
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset. The block has one clock; reset is asynchronous and active-low.
- `stage_slave_valid` input 1: transaction valid from the last walking stage.
- `stage_slave_ready` output 1: stage can accept. Driven from a register.
- `stage_slave_data` input `PIPELINE_SLAVE_DATA_WIDTH`: `mptw_transaction_t`.
- `stage_master_valid` output 1: response valid.
- `stage_master_ready` input 1: requester accepts the response.
- `stage_master_data` output `RESPONSE_DATA_WIDTH`: `mpt_response_t`.
- `fault_valid_o` output 1: sticky; a deny has been captured.
- `fault_addr_o` output 64: address of the first captured deny.
- `fault_cause_o` output `mpt_check_cause_e`: cause of the first captured deny.
- `fault_count_o` output `FAULT_COUNT_WIDTH`: saturating count of all denies.
- `fault_clear_i` input 1: single-cycle pulse that clears the log and the counter.

## Operation

- The input side is a 2-entry skid buffer made of a main slot and a skid slot. The output side is one registered response slot.
- Transfer rule: a handshake occurs on a cycle where both `valid` and `ready` are high.
- `stage_slave_ready` = skid slot empty (registered).
- A transaction with `data.valid`=0 is consumed and produces no response. This is the bubble convention inherited from the walking stages.
- Decision logic (combinational, applied to the head slot):
  - `fault` set → deny, cause `MPT_CAUSE_WALK_FAULT`.
  - `walking`==`MPT_WALKING_SKIP` → allow, cause `MPT_CAUSE_NONE`. This covers bare mode and addresses outside the MPT.
  - `perm`.W=1 and `perm`.R=0 → deny, cause `MPT_CAUSE_PERM_FORMAT`. This encoding is reserved.
  - `access`=READ needs R; WRITE needs R and W; EXEC needs X. A missing bit → deny, cause `MPT_CAUSE_PERM_DENIED`.
  - Otherwise → allow.
- Response fields: `valid`=1, `allow`, `cause`, `addr` (copied from the transaction), `id` (copied from the transaction).
- Responses leave in arrival order. The stage never reorders.
- Deny accounting happens when a deny response is loaded into the output slot, not when it is accepted downstream:
  - `fault_count_o` increments and saturates at all-ones.
  - If `fault_valid_o`=0, the block captures `addr` and `cause` and sets `fault_valid_o`.
  - Later denies do not overwrite the captured entry.
- `fault_clear_i` clears `fault_valid_o`, `fault_addr_o`, `fault_cause_o` and `fault_count_o`.
- If `fault_clear_i` and a deny load happen in the same cycle, the deny wins: the counter becomes 1 and the log holds the new deny.

## Timing

- Reset values: `stage_slave_ready`=1, `stage_master_valid`=0, `stage_master_data`=0, `fault_valid_o`=0, `fault_addr_o`=0, `fault_cause_o`=`MPT_CAUSE_NONE`, `fault_count_o`=0. Both buffer slots reset to empty.
- Latency: a transaction accepted in cycle N gives `stage_master_valid`=1 in cycle N+1, provided the output slot is free or draining in cycle N.
- Throughput: one transaction per cycle with `stage_master_ready` held high.
- Backpressure:
  - While `stage_master_ready`=0, the output slot holds.
  - The main slot fills, then the skid slot fills.
  - `stage_slave_ready` drops in the cycle after the skid slot fills.
  - At most 2 transactions are buffered plus 1 response.
- While `stage_master_valid` is high, `stage_master_data` must stay stable until the handshake completes.
- Buffer full and output draining in the same cycle: the buffer shifts forward and ready rises in the next cycle. No transaction is lost or duplicated.
- Reset asserted mid-operation: every slot is discarded immediately, with no partial response. The log and counter clear.

## Configuration

- Macro: `MPT_CHECK_FAULT_LOG_EN`.
- Defined: the sticky log, the counter and `fault_clear_i` behave as described above.
- Not defined:
  - The log registers and counter are not built.
  - `fault_valid_o`, `fault_addr_o` and `fault_count_o` are tied to 0, and `fault_cause_o` to `MPT_CAUSE_NONE`.
  - `fault_clear_i` is ignored.
  - Response behaviour and timing are unchanged.

## Structure

- Additions to `mpt_pkg`:
  - `mpt_access_e` with values READ, WRITE, EXEC.
  - `mpt_check_cause_e` with values NONE, WALK_FAULT, PERM_DENIED, PERM_FORMAT.
  - `mpt_response_t`.
  - the `MPT_WALKING_SKIP` value in the walking enum.
  - the `perm`, `access`, `id` and `fault` fields in `mptw_transaction_t`.
- Sub-module: `mpt_perm_decoder`, purely combinational. Input: transaction. Outputs: `allow` and `cause`. It is reused by the future PLB hit path.
- Output register: the existing `pipeline_register`. The skid buffer is local to this block.

## Test plan

- READ, perm=R, `stage_master_ready`=1 → in the next cycle allow=1, cause=NONE, `addr` and `id` echoed.
- WRITE, perm=R only → deny, cause=PERM_DENIED, `fault_count_o`=1, `fault_valid_o`=1, `fault_addr_o` equal to the transaction address.
- WRITE, perm=W only → deny with PERM_FORMAT. A second deny (EXEC, perm=R) → count=2, while the log still holds the first address and PERM_FORMAT.
- `stage_master_ready`=0 for 5 cycles while sending 4 back-to-back transactions → `stage_slave_ready` drops after 3 are accepted. On release, all 4 responses arrive in order with no gap.
- A `data.valid`=0 bubble between two valid transactions → exactly 2 responses. `fault_clear_i` pulsed in the same cycle as a deny load → count=1, log holds the new deny.
- Reset asserted while the buffer is full → every output returns to its reset value within the same cycle, and `stage_slave_ready`=1 after release.
